// File: rtl/tinker_regfile_mp.sv
// Multi-port register file with per-register pending-producer counters for RAW hazard detection.
// Define TINKER_RF_BYPASS_EN to forward same-cycle writes onto rd_data/stack_ptr/rd_busy.
module tinker_regfile_mp #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     NREGS    = 32,
    parameter int unsigned     NRD      = 6,
    parameter int unsigned     NWR      = 2,
    parameter int unsigned     CNT_W    = 2,
    parameter int unsigned     SP_IDX   = 31,
    parameter logic [XLEN-1:0] SP_RESET = 'h80000,
    localparam int unsigned    AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NWR-1:0]      alloc_en,
    input  logic [NWR*AW-1:0]   alloc_addr,
    output logic [NWR-1:0]      alloc_rdy,
    output logic [XLEN-1:0]     stack_ptr,
    output logic                sb_err
);

    localparam int unsigned CMAX = (1 << CNT_W) - 1;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [CNT_W-1:0] cnt_q  [NREGS];
    logic [CNT_W-1:0] cnt_d  [NREGS];
    logic             sb_err_q, sb_err_d;
    logic [NWR-1:0]   alloc_ok;

    always_comb begin
        int unsigned prior, a_n, w_n;
        prior     = 0;
        a_n       = 0;
        w_n       = 0;
        alloc_rdy = '0;
        alloc_ok  = '0;
        // Lower-index enabled allocs to the same register consume headroom first.
        for (int unsigned j = 0; j < NWR; j++) begin
            prior = 0;
            for (int unsigned k = 0; k < j; k++)
                if (alloc_en[k] && alloc_addr[k*AW +: AW] == alloc_addr[j*AW +: AW])
                    prior++;
            alloc_rdy[j] = (32'(cnt_q[alloc_addr[j*AW +: AW]]) + prior) < CMAX;
            alloc_ok[j]  = alloc_en[j] && alloc_rdy[j];
        end

        sb_err_d = sb_err_q;
        for (int unsigned r = 0; r < NREGS; r++) begin
            a_n = 0;
            w_n = 0;
            for (int unsigned j = 0; j < NWR; j++) begin
                if (alloc_ok[j] && alloc_addr[j*AW +: AW] == AW'(r)) a_n++;
                if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(r)) w_n++;
            end
            if (32'(cnt_q[r]) + a_n < w_n) begin
                cnt_d[r] = '0;
                sb_err_d = 1'b1;
            end else begin
                cnt_d[r] = CNT_W'(32'(cnt_q[r]) + a_n - w_n);
            end
        end

        regs_d = regs_q;
        for (int unsigned j = 0; j < NWR; j++)
            if (wr_en[j]) regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= (r == SP_IDX) ? SP_RESET : '0;
                cnt_q[r]  <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
        end
    end

    always_comb begin
        logic [AW-1:0] ra;
`ifdef TINKER_RF_BYPASS_EN
        int unsigned w_n;
        w_n = 0;
`endif
        ra      = '0;
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            ra                      = rd_addr[i*AW +: AW];
            rd_data[i*XLEN +: XLEN] = regs_q[ra];
            rd_busy[i]              = cnt_q[ra] != '0;
`ifdef TINKER_RF_BYPASS_EN
            // Ascending scan so the highest-index matching write port is forwarded.
            w_n = 0;
            for (int unsigned j = 0; j < NWR; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] == ra) begin
                    rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                    w_n++;
                end
            end
            rd_busy[i] = 32'(cnt_q[ra]) > w_n;
`endif
        end
    end

    always_comb begin
        stack_ptr = regs_q[AW'(SP_IDX)];
`ifdef TINKER_RF_BYPASS_EN
        for (int unsigned j = 0; j < NWR; j++)
            if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(SP_IDX))
                stack_ptr = wr_data[j*XLEN +: XLEN];
`endif
    end

    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_tinker_regfile_mp.sv
// Scoreboard bench for tinker_regfile_mp: directed hazard scenarios followed by random traffic.
module tb_tinker_regfile_mp;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 6;
    localparam int unsigned NWR   = 2;
    localparam int unsigned AW    = 5;
    localparam int unsigned CMAX  = 3;
    localparam logic [XLEN-1:0] SP_RST = 64'h80000;

    logic                clk = 1'b0;
    logic                s_rst;
    logic [NRD*AW-1:0]   s_ra;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      s_we;
    logic [NWR*AW-1:0]   s_wa;
    logic [NWR*XLEN-1:0] s_wd;
    logic [NWR-1:0]      s_ae;
    logic [NWR*AW-1:0]   s_aa;
    logic [NWR-1:0]      alloc_rdy;
    logic [XLEN-1:0]     stack_ptr;
    logic                sb_err;

    tinker_regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
        .CNT_W(2), .SP_IDX(31), .SP_RESET(SP_RST)
    ) dut (
        .clk(clk), .reset(s_rst),
        .rd_addr(s_ra), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(s_we), .wr_addr(s_wa), .wr_data(s_wd),
        .alloc_en(s_ae), .alloc_addr(s_aa), .alloc_rdy(alloc_rdy),
        .stack_ptr(stack_ptr), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NRD*XLEN-1:0] rd;
        logic [NRD-1:0]      busy;
        logic [NWR-1:0]      ardy;
        logic [XLEN-1:0]     sp;
        logic                err;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: plain arrays updated once per cycle from the architectural rules.
    logic [XLEN-1:0] m_regs [NREGS];
    int unsigned     m_cnt  [NREGS];
    logic            m_err;
    bit              m_valid = 0;

    task automatic chk(input string name, input logic [NRD*XLEN-1:0] act, input logic [NRD*XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd_data",   rd_data,   e.rd);
                chk("rd_busy",   rd_busy,   e.busy);
                chk("alloc_rdy", alloc_rdy, e.ardy);
                chk("stack_ptr", stack_ptr, e.sp);
                chk("sb_err",    sb_err,    e.err);
            end
        end
    end

    function automatic int unsigned fld(input logic [NWR*AW-1:0] v, input int unsigned j);
        return int'(v[j*AW +: AW]);
    endfunction

    task automatic step();
        exp_t e;
        int unsigned a[NREGS];
        int unsigned w[NREGS];
        int unsigned prior, r, n;
        for (int unsigned j = 0; j < NWR; j++) begin
            prior = 0;
            for (int unsigned k = 0; k < j; k++)
                if (s_ae[k] && fld(s_aa, k) == fld(s_aa, j)) prior++;
            e.ardy[j] = (m_cnt[fld(s_aa, j)] + prior) < CMAX;
        end
        for (int unsigned i = 0; i < NRD; i++) begin
            r = int'(s_ra[i*AW +: AW]);
            e.rd[i*XLEN +: XLEN] = m_regs[r];
            n = 0;
`ifdef TINKER_RF_BYPASS_EN
            for (int unsigned j = 0; j < NWR; j++)
                if (s_we[j] && fld(s_wa, j) == r) begin
                    e.rd[i*XLEN +: XLEN] = s_wd[j*XLEN +: XLEN];
                    n++;
                end
`endif
            e.busy[i] = m_cnt[r] > n;
        end
        e.sp = m_regs[31];
`ifdef TINKER_RF_BYPASS_EN
        for (int unsigned j = 0; j < NWR; j++)
            if (s_we[j] && fld(s_wa, j) == 31) e.sp = s_wd[j*XLEN +: XLEN];
`endif
        e.err = m_err;
        if (m_valid) q.push_back(e);

        if (s_rst) begin
            for (int unsigned k = 0; k < NREGS; k++) begin
                m_regs[k] = '0;
                m_cnt[k]  = 0;
            end
            m_regs[31] = SP_RST;
            m_err      = 1'b0;
            m_valid    = 1;
        end else begin
            for (int unsigned k = 0; k < NREGS; k++) begin
                a[k] = 0;
                w[k] = 0;
            end
            for (int unsigned j = 0; j < NWR; j++) begin
                if (s_ae[j] && e.ardy[j]) a[fld(s_aa, j)]++;
                if (s_we[j]) begin
                    m_regs[fld(s_wa, j)] = s_wd[j*XLEN +: XLEN];
                    w[fld(s_wa, j)]++;
                end
            end
            for (int unsigned k = 0; k < NREGS; k++) begin
                if (m_cnt[k] + a[k] < w[k]) begin
                    m_cnt[k] = 0;
                    m_err    = 1'b1;
                end else begin
                    m_cnt[k] = m_cnt[k] + a[k] - w[k];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        s_rst = 1'b0; s_we = '0; s_ae = '0; s_wd = '0;
    endtask
    task automatic wr(input int unsigned j, input int unsigned ad, input logic [XLEN-1:0] d);
        s_we[j] = 1'b1; s_wa[j*AW +: AW] = AW'(ad); s_wd[j*XLEN +: XLEN] = d;
    endtask
    task automatic al(input int unsigned j, input int unsigned ad);
        s_ae[j] = 1'b1; s_aa[j*AW +: AW] = AW'(ad);
    endtask
    task automatic rdset(input int unsigned a0, a1, a2, a3, a4, a5);
        s_ra = {AW'(a5), AW'(a4), AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endtask

    initial begin
        s_wa = '0; s_aa = '0;
        clr();
        rdset(31, 1, 0, 5, 7, 9);
        // Reset with same-edge write/alloc to r1: reset must win.
        s_rst = 1'b1; wr(0, 1, 64'hdead); al(0, 1);
        step(); step();
        clr(); step();
        // Two writes to r5 in one cycle: port 1 wins.
        wr(0, 5, 64'h11); wr(1, 5, 64'h22); step();
        clr(); step();
        // Fill r7 to CMAX, try a fourth alloc, then retire all three.
        for (int n = 0; n < 4; n++) begin clr(); al(0, 7); step(); end
        for (int n = 0; n < 3; n++) begin clr(); wr(n % 2, 7, 64'h700 + 64'(n)); step(); end
        clr(); step();
        // Dual-port alloc to the same register exercises lower-index headroom accounting.
        rdset(10, 10, 31, 3, 9, 2);
        for (int n = 0; n < 2; n++) begin clr(); al(0, 10); al(1, 10); step(); end
        // Underflow on r3, then sticky error.
        clr(); wr(0, 3, 64'h33); step();
        clr(); step(); step();
        // Pending r9 written while being read.
        clr(); al(1, 9); step();
        clr(); wr(0, 9, 64'habc); step();
        clr(); step();
        // Stack pointer update.
        clr(); wr(1, 31, 64'h7fff0); step();
        clr(); s_rst = 1'b1; step();
        clr(); step();

        for (int n = 0; n < 600; n++) begin
            clr();
            for (int unsigned j = 0; j < NWR; j++) begin
                if ($urandom_range(0, 2) == 0)
                    wr(j, ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 5), {$urandom, $urandom});
                if ($urandom_range(0, 1) == 0) al(j, $urandom_range(0, 5));
            end
            for (int unsigned i = 0; i < NRD; i++)
                s_ra[i*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 5));
            s_rst = ($urandom_range(0, 60) == 0);
            step();
        end

        // Reset with traffic to r1 while r1 holds data and a pending count.
        clr(); al(0, 1); wr(1, 1, 64'h1234); step();
        clr(); al(1, 1); step();
        clr(); s_rst = 1'b1; wr(0, 1, 64'h5678); al(0, 1); al(1, 1); rdset(1, 1, 31, 0, 0, 0); step();
        clr(); step(); step();

        @(negedge clk); @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
